// File: rtl/branch_predictor.sv
// Branch target buffer with saturating-counter direction prediction.
// Lookup is combinational on the fetch PC; training happens on the clock edge
// from the branch/jump resolved in Execute. HIST_WIDTH=0 gives bimodal
// indexing, HIST_WIDTH>0 XORs global history into the index (gshare).
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 16,
  parameter int CTR_WIDTH  = 2,
  parameter int HIST_WIDTH = 0,
  localparam int IDXW      = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  // Fetch-side prediction
  input  logic [DATA_WIDTH-1:0] PCF,
  output logic                  predTakenF,
  output logic [DATA_WIDTH-1:0] predTargetF,
  output logic [IDXW-1:0]       predIndexF,
  // Execute-side resolution
  input  logic                  updateE,
  input  logic                  isJumpE,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic                  takenE,
  input  logic [DATA_WIDTH-1:0] targetE,
  input  logic [IDXW-1:0]       indexE,
  input  logic                  predTakenE,
  input  logic [DATA_WIDTH-1:0] predTargetE,
  output logic                  mispredictE,
  output logic [DATA_WIDTH-1:0] redirectPCE,
  output logic [DATA_WIDTH-1:0] resolvedCount,
  output logic [DATA_WIDTH-1:0] mispredictCount
);

  localparam int TAGW = DATA_WIDTH - IDXW - 2;

  localparam logic [CTR_WIDTH-1:0] CTR_MAX     = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK_T  = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK_NT = CTR_MAX >> 1;

  // Table storage, split so only the fields that define visibility are reset
  logic                  validTbl  [ENTRIES];
  logic [CTR_WIDTH-1:0]  ctrTbl    [ENTRIES];
  logic [TAGW-1:0]       tagTbl    [ENTRIES];
  logic [DATA_WIDTH-1:0] targetTbl [ENTRIES];

  // History contribution to the index (zero for bimodal)
  logic [IDXW-1:0] ghrIdx;

  // ---------------------------------------------------------------------------
  // Fetch lookup
  // ---------------------------------------------------------------------------
  logic hitF;

  assign predIndexF  = PCF[IDXW+1:2] ^ ghrIdx;
  assign hitF        = validTbl[predIndexF] &&
                       (tagTbl[predIndexF] == PCF[DATA_WIDTH-1:IDXW+2]);
  assign predTakenF  = hitF & ctrTbl[predIndexF][CTR_WIDTH-1];
  assign predTargetF = predTakenF ? targetTbl[predIndexF] : PCF + DATA_WIDTH'(4);

  // ---------------------------------------------------------------------------
  // Execute resolution
  // ---------------------------------------------------------------------------
  assign mispredictE = updateE & ((takenE != predTakenE) |
                                  (takenE & (targetE != predTargetE)));
  assign redirectPCE = takenE ? targetE : PCE + DATA_WIDTH'(4);

  logic [TAGW-1:0]      tagE;
  logic                 hitE;
  logic                 wrEntry;
  logic                 wrCtr;
  logic [CTR_WIDTH-1:0] ctrCur;
  logic [CTR_WIDTH-1:0] ctrNext;

  assign tagE    = PCE[DATA_WIDTH-1:IDXW+2];
  assign hitE    = validTbl[indexE] && (tagTbl[indexE] == tagE);
  assign ctrCur  = ctrTbl[indexE];
  // Tag/target are (re)written on any taken outcome or any jump hit;
  // a miss that was not taken leaves the entry alone.
  assign wrEntry = updateE & (hitE ? (isJumpE | takenE) : takenE);
  assign wrCtr   = updateE & (hitE | takenE);

  // Next counter value for the entry being trained
  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
    ctrNext = ctrCur;
    if (!hitE) begin
      ctrNext = isJumpE ? CTR_MAX : CTR_WEAK_T;
    end else if (isJumpE) begin
      ctrNext = CTR_MAX;
    end else if (takenE) begin
      if (ctrCur != CTR_MAX) ctrNext = ctrCur + CTR_WIDTH'(1);
    end else begin
      if (ctrCur != '0) ctrNext = ctrCur - CTR_WIDTH'(1);
    end
  end

  // Valid bits and counters: cleared to weakly not-taken on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        // NOTE: non-blocking assignments for all sequential state, so every
        // register samples pre-edge values regardless of statement order.
        validTbl[i] <= 1'b0;
        ctrTbl[i]   <= CTR_WEAK_NT;
      end
    end else if (wrCtr) begin
      validTbl[indexE] <= 1'b1;
      ctrTbl[indexE]   <= ctrNext;
    end
  end

  // Tag and target payload
  // NOTE: this storage is deliberately not reset; an entry is only ever read
  // through its valid bit, so stale payload after reset is invisible.
  always_ff @(posedge clk) begin
    if (wrEntry) begin
      tagTbl[indexE]    <= tagE;
      targetTbl[indexE] <= targetE;
    end
  end

  // Resolution statistics, wrapping naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resolvedCount   <= '0;
      mispredictCount <= '0;
    end else begin
      if (updateE)     resolvedCount   <= resolvedCount + DATA_WIDTH'(1);
      if (mispredictE) mispredictCount <= mispredictCount + DATA_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Global history (only conditional branches shift in their outcome)
  // ---------------------------------------------------------------------------
  generate
    if (HIST_WIDTH > 0) begin : gHist
      logic [HIST_WIDTH-1:0] ghr;

      // Shift register of recent conditional outcomes
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ghr <= '0;
        end else if (updateE && !isJumpE) begin
          ghr <= HIST_WIDTH'({ghr, takenE});
        end
      end

      assign ghrIdx = IDXW'(ghr);
    end else begin : gNoHist
      assign ghrIdx = '0;
    end
  endgenerate

  // Byte-offset bits and the PC index field are not needed (indexE carries it)
  logic unusedPcBits;
  assign unusedPcBits = ^{PCF[1:0], PCE[IDXW+1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a bimodal instance driven from a
// vector table, plus a gshare instance for history and async-reset sequences.
module tb_branch_predictor;

  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] PCF;
  logic          updateE, isJumpE, takenE, predTakenE;
  logic [DW-1:0] PCE, targetE, predTargetE;
  logic [IW-1:0] indexE;

  logic          predTakenF, mispredictE;
  logic [DW-1:0] predTargetF, redirectPCE, resolvedCount, mispredictCount;
  logic [IW-1:0] predIndexF;

  // gshare instance: own update strobes, other inputs shared
  logic          gUpd, gJmp, gTkn;
  logic          gPredTakenF, gMispredictE;
  logic [DW-1:0] gPredTargetF, gRedirectPCE, gResolvedCount, gMispredictCount;
  logic [IW-1:0] gPredIndexF;

  always #5 clk = ~clk;

  branch_predictor #(.DATA_WIDTH(DW), .ENTRIES(16), .CTR_WIDTH(2), .HIST_WIDTH(0)) dut (
    .clk(clk), .rst(rst), .PCF(PCF),
    .predTakenF(predTakenF), .predTargetF(predTargetF), .predIndexF(predIndexF),
    .updateE(updateE), .isJumpE(isJumpE), .PCE(PCE), .takenE(takenE),
    .targetE(targetE), .indexE(indexE), .predTakenE(predTakenE),
    .predTargetE(predTargetE), .mispredictE(mispredictE), .redirectPCE(redirectPCE),
    .resolvedCount(resolvedCount), .mispredictCount(mispredictCount)
  );

  branch_predictor #(.DATA_WIDTH(DW), .ENTRIES(16), .CTR_WIDTH(2), .HIST_WIDTH(2)) dutG (
    .clk(clk), .rst(rst), .PCF(PCF),
    .predTakenF(gPredTakenF), .predTargetF(gPredTargetF), .predIndexF(gPredIndexF),
    .updateE(gUpd), .isJumpE(gJmp), .PCE(PCE), .takenE(gTkn),
    .targetE(targetE), .indexE(indexE), .predTakenE(predTakenE),
    .predTargetE(predTargetE), .mispredictE(gMispredictE), .redirectPCE(gRedirectPCE),
    .resolvedCount(gResolvedCount), .mispredictCount(gMispredictCount)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          upd, jmp, tkn, ptkE;
    logic [DW-1:0] pce, tgt, ptgtE, pcf;
    logic [IW-1:0] idx;
    logic          eTkn, eMisp;
    logic [DW-1:0] eTgt, eRedir;
    logic [IW-1:0] eIdx;
  } vec_t;

  function automatic vec_t mk(
    input logic upd, input logic jmp, input logic [DW-1:0] pce, input logic tkn,
    input logic [DW-1:0] tgt, input logic [IW-1:0] idx, input logic ptkE,
    input logic [DW-1:0] ptgtE, input logic [DW-1:0] pcf, input logic eTkn,
    input logic [DW-1:0] eTgt, input logic [IW-1:0] eIdx, input logic eMisp,
    input logic [DW-1:0] eRedir);
    vec_t v;
    v.upd = upd; v.jmp = jmp; v.pce = pce; v.tkn = tkn; v.tgt = tgt; v.idx = idx;
    v.ptkE = ptkE; v.ptgtE = ptgtE; v.pcf = pcf; v.eTkn = eTkn; v.eTgt = eTgt;
    v.eIdx = eIdx; v.eMisp = eMisp; v.eRedir = eRedir;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int expResolved = 0;
    int expMisp     = 0;

    // Each row: inputs for one cycle, and the combinational outputs expected
    // in that cycle (state as it was before this cycle's edge).
    //               upd jmp pce      tkn tgt     idx ptkE ptgtE    pcf      eTkn eTgt     eIdx eMisp eRedir
    vecs.push_back(mk(0, 0, 32'h00,  0, 32'h000, 0,  0, 32'h000, 32'h40, 0, 32'h044, 0,  0, 32'h000)); // reset view
    vecs.push_back(mk(1, 0, 32'h40,  1, 32'h100, 0,  0, 32'h044, 32'h40, 0, 32'h044, 0,  1, 32'h100)); // allocate
    vecs.push_back(mk(0, 0, 32'h00,  0, 32'h000, 0,  0, 32'h000, 32'h40, 1, 32'h100, 0,  0, 32'h000)); // ctr 10
    vecs.push_back(mk(1, 0, 32'h40,  0, 32'h100, 0,  1, 32'h100, 32'h40, 1, 32'h100, 0,  1, 32'h044)); // ->01
    vecs.push_back(mk(1, 0, 32'h40,  0, 32'h100, 0,  0, 32'h044, 32'h40, 0, 32'h044, 0,  0, 32'h044)); // ->00
    vecs.push_back(mk(1, 0, 32'h40,  0, 32'h100, 0,  0, 32'h044, 32'h40, 0, 32'h044, 0,  0, 32'h044)); // ->00 floor
    vecs.push_back(mk(1, 0, 32'h40,  1, 32'h100, 0,  0, 32'h044, 32'h40, 0, 32'h044, 0,  1, 32'h100)); // ->01
    vecs.push_back(mk(1, 0, 32'h40,  1, 32'h100, 0,  0, 32'h044, 32'h40, 0, 32'h044, 0,  1, 32'h100)); // ->10
    vecs.push_back(mk(1, 0, 32'h40,  1, 32'h100, 0,  1, 32'h100, 32'h40, 1, 32'h100, 0,  0, 32'h100)); // ->11
    vecs.push_back(mk(1, 0, 32'h40,  1, 32'h100, 0,  1, 32'h100, 32'h40, 1, 32'h100, 0,  0, 32'h100)); // ->11 cap
    vecs.push_back(mk(1, 0, 32'h40,  0, 32'h100, 0,  1, 32'h100, 32'h40, 1, 32'h100, 0,  1, 32'h044)); // ->10
    vecs.push_back(mk(0, 0, 32'h00,  0, 32'h000, 0,  0, 32'h000, 32'h40, 1, 32'h100, 0,  0, 32'h000)); // still taken
    vecs.push_back(mk(0, 0, 32'h00,  0, 32'h000, 0,  0, 32'h000, 32'h80, 0, 32'h084, 0,  0, 32'h000)); // alias miss
    vecs.push_back(mk(1, 0, 32'h80,  1, 32'h200, 0,  0, 32'h084, 32'h80, 0, 32'h084, 0,  1, 32'h200)); // replace
    vecs.push_back(mk(0, 0, 32'h00,  0, 32'h000, 0,  0, 32'h000, 32'h80, 1, 32'h200, 0,  0, 32'h000));
    vecs.push_back(mk(0, 0, 32'h00,  0, 32'h000, 0,  0, 32'h000, 32'h40, 0, 32'h044, 0,  0, 32'h000)); // 0x40 evicted
    vecs.push_back(mk(1, 0, 32'h40,  1, 32'h104, 0,  1, 32'h100, 32'h40, 0, 32'h044, 0,  1, 32'h104)); // wrong target
    vecs.push_back(mk(0, 0, 32'h00,  0, 32'h000, 0,  0, 32'h000, 32'h40, 1, 32'h104, 0,  0, 32'h000));
    vecs.push_back(mk(1, 1, 32'h40,  1, 32'h108, 0,  1, 32'h104, 32'h44, 0, 32'h048, 1,  1, 32'h108)); // jump hit ->11
    vecs.push_back(mk(1, 0, 32'h40,  0, 32'h108, 0,  1, 32'h108, 32'h40, 1, 32'h108, 0,  1, 32'h044)); // ->10
    vecs.push_back(mk(0, 0, 32'h00,  0, 32'h000, 0,  0, 32'h000, 32'h40, 1, 32'h108, 0,  0, 32'h000));
    vecs.push_back(mk(1, 0, 32'h48,  0, 32'h000, 2,  0, 32'h04c, 32'h48, 0, 32'h04c, 2,  0, 32'h04c)); // miss, not taken
    vecs.push_back(mk(0, 0, 32'h00,  0, 32'h000, 0,  0, 32'h000, 32'h48, 0, 32'h04c, 2,  0, 32'h000));
    vecs.push_back(mk(1, 1, 32'h7c,  1, 32'h300, 15, 0, 32'h080, 32'h7c, 0, 32'h080, 15, 1, 32'h300)); // jump alloc ->11
    vecs.push_back(mk(1, 0, 32'h7c,  0, 32'h300, 15, 1, 32'h300, 32'h7c, 1, 32'h300, 15, 1, 32'h080)); // ->10
    vecs.push_back(mk(0, 0, 32'h00,  0, 32'h000, 0,  0, 32'h000, 32'h7c, 1, 32'h300, 15, 0, 32'h000));

    rst = 1'b1; PCF = 32'h40; updateE = 0; isJumpE = 0; takenE = 0; predTakenE = 0;
    PCE = '0; targetE = '0; predTargetE = '0; indexE = '0;
    gUpd = 0; gJmp = 0; gTkn = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---- table-driven run on the bimodal instance ----
    foreach (vecs[i]) begin
      @(negedge clk);
      updateE = vecs[i].upd; isJumpE = vecs[i].jmp; PCE = vecs[i].pce;
      takenE = vecs[i].tkn; targetE = vecs[i].tgt; indexE = vecs[i].idx;
      predTakenE = vecs[i].ptkE; predTargetE = vecs[i].ptgtE; PCF = vecs[i].pcf;
      #1;
      check($sformatf("row%0d predTakenF", i),  predTakenF,  vecs[i].eTkn);
      check($sformatf("row%0d predTargetF", i), predTargetF, vecs[i].eTgt);
      check($sformatf("row%0d predIndexF", i),  predIndexF,  vecs[i].eIdx);
      check($sformatf("row%0d mispredictE", i), mispredictE, vecs[i].eMisp);
      if (vecs[i].upd) check($sformatf("row%0d redirectPCE", i), redirectPCE, vecs[i].eRedir);
      check($sformatf("row%0d resolvedCount", i),   resolvedCount,   DW'(expResolved));
      check($sformatf("row%0d mispredictCount", i), mispredictCount, DW'(expMisp));
      if (vecs[i].upd)   expResolved++;
      if (vecs[i].eMisp) expMisp++;
    end

    @(negedge clk);
    updateE = 0;
    #1;
    check("final resolvedCount", resolvedCount, DW'(16));
    check("final mispredictCount", mispredictCount, DW'(11));

    // ---- gshare history on the HIST_WIDTH=2 instance ----
    PCF = 32'h40; PCE = 32'h40; targetE = 32'h100; indexE = '0;
    predTakenE = 0; predTargetE = 32'h44;
    #1 check("g reset index", gPredIndexF, 4'd0);
    @(negedge clk); gUpd = 1; gJmp = 0; gTkn = 1;
    #1 check("g index ghr00", gPredIndexF, 4'd0);
    @(negedge clk); gUpd = 1; gJmp = 1; gTkn = 1;
    #1 check("g index ghr01", gPredIndexF, 4'd1);
    @(negedge clk); gUpd = 1; gJmp = 0; gTkn = 1;
    #1 check("g index after jump", gPredIndexF, 4'd1);
    @(negedge clk); gUpd = 1; gJmp = 0; gTkn = 0;
    #1 check("g index ghr11", gPredIndexF, 4'd3);
    @(negedge clk); gUpd = 0; gJmp = 0; gTkn = 0;
    #1 check("g index ghr10", gPredIndexF, 4'd2);

    // ---- asynchronous reset between edges ----
    check("pre-reset predTakenF", predTakenF, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async rst g index", gPredIndexF, 4'd0);
    check("async rst predTakenF", predTakenF, 1'b0);
    check("async rst predTargetF", predTargetF, DW'(32'h44));
    check("async rst resolvedCount", resolvedCount, DW'(0));
    check("async rst mispredictCount", mispredictCount, DW'(0));

    // An update presented while reset is held across an edge is discarded
    @(negedge clk);
    updateE = 1; isJumpE = 0; PCE = 32'h40; takenE = 1; targetE = 32'h100;
    indexE = '0; predTakenE = 0; predTargetE = 32'h44;
    @(negedge clk);
    updateE = 0; rst = 1'b0;
    #1;
    check("discarded update predTakenF", predTakenF, 1'b0);
    check("discarded update resolvedCount", resolvedCount, DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
